// File: rtl/mul_shift_add_seq.sv
// mul_shift_add_seq: radix-2 shift-and-add sequential multiplier with start/ready/done handshake.
// Optional signed operation (magnitude multiply plus sign fix-up) when SIGNED_MUL_EN is defined.
module mul_shift_add_seq #(
  parameter int WIDTH      = 16,
  parameter int EARLY_EXIT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               sgn,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t             state_q, state_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d, acc_q, acc_d, prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d, a_mag, b_mag;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               last;
`ifdef SIGNED_MUL_EN
  logic neg_q, neg_d;
  // -2^(WIDTH-1) negates to itself, which read unsigned is the correct magnitude
  assign a_mag = (sgn && a_in[WIDTH-1]) ? -a_in : a_in;
  assign b_mag = (sgn && b_in[WIDTH-1]) ? -b_in : b_in;
`else
  logic sgn_unused;
  assign sgn_unused = sgn;
  assign a_mag = a_in;
  assign b_mag = b_in;
`endif
  assign last = (cnt_q == CW'(1)) || (EARLY_EXIT != 0 && (mplier_q >> 1) == '0);
  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    prod_d   = prod_q;
`ifdef SIGNED_MUL_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE: if (start) begin
        state_d  = RUN;
        mcand_d  = {{WIDTH{1'b0}}, a_mag};
        mplier_d = b_mag;
        acc_d    = '0;
        cnt_d    = CW'(WIDTH);
`ifdef SIGNED_MUL_EN
        neg_d    = sgn & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
`endif
      end
      RUN: begin
        acc_d    = mplier_q[0] ? acc_q + mcand_q : acc_q;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CW'(1);
        // load the result on the exit edge so it is already visible in DONE
        if (last) begin
          state_d = DONE;
`ifdef SIGNED_MUL_EN
          prod_d  = neg_q ? -acc_d : acc_d;
`else
          prod_d  = acc_d;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      prod_q   <= '0;
`ifdef SIGNED_MUL_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      prod_q   <= prod_d;
`ifdef SIGNED_MUL_EN
      neg_q    <= neg_d;
`endif
    end
  end
  assign ready   = state_q == IDLE;
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign product = prod_q;
endmodule
